vote_session_ctrl: RTL and testbench

Parametrised, sequential successor to the three-input majority voter. Collects at most one yes/no vote per voter from `N_VOTERS` channels within a session opened by `start`. Closes the session when every voter has voted or a cycle timeout expires, then reports a strict-majority verdict and the yes count. Absent voters count as "no". Sits between per-voter input logic (buttons/debouncers) and the result display.

---
 rtl/vote_session_ctrl.sv | 121 ++++++++++++
 tb/tb_vote_session_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// Voting session controller: opens a session on start, accepts at most one
// vote per voter, closes on full turnout or timeout, and reports a registered
// strict-majority verdict together with the yes count and turnout mask.
module vote_session_ctrl #(
  parameter int  N_VOTERS       = 3,
  parameter int  TIMEOUT_CYCLES = 16,
  localparam int CW             = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CW-1:0]       yes_count,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic                timed_out
);

  // Timer counts COLLECT edges; it is at least one bit wide even for a
  // single-cycle timeout.
  localparam int                TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [N_VOTERS-1:0] ALL  = '1;
  localparam logic [CW:0]       N_EXT  = (CW + 1)'(N_VOTERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [TW-1:0]       timer;
  logic [N_VOTERS-1:0] accept;
  logic [N_VOTERS-1:0] mask_next;
  logic [CW-1:0]       add_count;
  logic [CW-1:0]       count_next;
  logic [CW:0]         twice_count;
  logic                all_voted;
  logic                expire;
  logic                close;

  // Handshake: a voter's vote is taken on any COLLECT edge where its
  // vote_valid bit is high and its mask bit is still clear; there is no
  // ready/back-pressure, later votes from the same voter are dropped.

  // Vote acceptance, popcount of new yes votes and session close decision.
  always_comb begin
    accept    = vote_valid & ~voted_mask;
    mask_next = voted_mask | accept;
    add_count = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      add_count = add_count + CW'(accept[i] & vote_yes[i]);
    end
    count_next  = yes_count + add_count;
    twice_count = {count_next, 1'b0};
    all_voted   = (mask_next == ALL);
    expire      = (timer == T_LAST);
    close       = all_voted | expire;
  end

  // Next-state logic for the session FSM.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_COLLECT;
      S_COLLECT: if (close) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Session datapath: clear on accepted start, accumulate in COLLECT,
  // latch verdict at the closing edge, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= '0;
      voted_mask <= '0;
      yes_count  <= '0;
      pass       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            timer      <= '0;
            voted_mask <= '0;
            yes_count  <= '0;
            pass       <= 1'b0;
            timed_out  <= 1'b0;
          end
        end
        S_COLLECT: begin
          voted_mask <= mask_next;
          yes_count  <= count_next;
          timer      <= timer + TW'(1);
          if (close) begin
            pass      <= (twice_count > N_EXT);
            timed_out <= ~all_voted;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode the state register directly.
  assign busy = (state == S_COLLECT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: three instances (3, 4 and 5 voters, timeout 8)
// share one stimulus stream; a session-level model predicts every output of
// every instance each cycle, and directed literal checks pin the model.
module tb_vote_session_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] vv = '0;
  logic [4:0] vy = '0;

  int checks = 0;
  int failures = 0;

  // DUT outputs
  logic       busy3, done3, pass3, to3;
  logic [1:0] yc3;
  logic [2:0] mask3;
  logic       busy4, done4, pass4, to4;
  logic [2:0] yc4;
  logic [3:0] mask4;
  logic       busy5, done5, pass5, to5;
  logic [2:0] yc5;
  logic [4:0] mask5;

  vote_session_ctrl #(.N_VOTERS(3), .TIMEOUT_CYCLES(TO)) dut3 (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vv[2:0]), .vote_yes(vy[2:0]),
    .busy(busy3), .done(done3), .pass(pass3), .yes_count(yc3),
    .voted_mask(mask3), .timed_out(to3));

  vote_session_ctrl #(.N_VOTERS(4), .TIMEOUT_CYCLES(TO)) dut4 (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vv[3:0]), .vote_yes(vy[3:0]),
    .busy(busy4), .done(done4), .pass(pass4), .yes_count(yc4),
    .voted_mask(mask4), .timed_out(to4));

  vote_session_ctrl #(.N_VOTERS(5), .TIMEOUT_CYCLES(TO)) dut5 (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vv), .vote_yes(vy),
    .busy(busy5), .done(done5), .pass(pass5), .yes_count(yc5),
    .voted_mask(mask5), .timed_out(to5));

  // Uniform views of the three instances.
  logic        d_busy [3];
  logic        d_done [3];
  logic        d_pass [3];
  logic        d_to   [3];
  logic [31:0] d_yes  [3];
  logic [31:0] d_mask [3];

  assign d_busy[0] = busy3;  assign d_busy[1] = busy4;  assign d_busy[2] = busy5;
  assign d_done[0] = done3;  assign d_done[1] = done4;  assign d_done[2] = done5;
  assign d_pass[0] = pass3;  assign d_pass[1] = pass4;  assign d_pass[2] = pass5;
  assign d_to[0]   = to3;    assign d_to[1]   = to4;    assign d_to[2]   = to5;
  assign d_yes[0]  = {30'b0, yc3};   assign d_yes[1]  = {29'b0, yc4};   assign d_yes[2]  = {29'b0, yc5};
  assign d_mask[0] = {29'b0, mask3}; assign d_mask[1] = {28'b0, mask4}; assign d_mask[2] = {27'b0, mask5};

  // Clock / reset block
  always #5 clk = ~clk;

  // Session model: phase 0 idle, 1 collecting, 2 reporting.
  int          n_of [3] = '{3, 4, 5};
  int          m_phase [3] = '{0, 0, 0};
  int          m_edges [3] = '{0, 0, 0};
  int          m_yes   [3] = '{0, 0, 0};
  logic [31:0] m_mask  [3] = '{0, 0, 0};
  logic        m_pass  [3] = '{0, 0, 0};
  logic        m_to    [3] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_phase[k] = 0; m_edges[k] = 0; m_yes[k] = 0;
        m_mask[k] = 0; m_pass[k] = 0; m_to[k] = 0;
      end else if (m_phase[k] == 0) begin
        if (start) begin
          m_phase[k] = 1; m_edges[k] = 0; m_yes[k] = 0;
          m_mask[k] = 0; m_pass[k] = 0; m_to[k] = 0;
        end
      end else if (m_phase[k] == 1) begin
        bit everyone;
        m_edges[k]++;
        for (int i = 0; i < n_of[k]; i++) begin
          if (vv[i] && !m_mask[k][i]) begin
            m_mask[k][i] = 1'b1;
            if (vy[i]) m_yes[k]++;
          end
        end
        everyone = 1'b1;
        for (int i = 0; i < n_of[k]; i++) if (!m_mask[k][i]) everyone = 1'b0;
        if (everyone || m_edges[k] == TO) begin
          m_phase[k] = 2;
          m_pass[k]  = (2 * m_yes[k] > n_of[k]);
          m_to[k]    = !everyone;
        end
      end else begin
        m_phase[k] = 0;
      end
    end
  end

  // Scoreboard
  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (n=%0d) at %0t: got %0h expected %0h", name, n_of[k], $time, act, exp);
    end
  endtask

  logic prev_done [3] = '{0, 0, 0};

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        check("busy", k, 32'(d_busy[k]), 32'(m_phase[k] == 1));
        check("done", k, 32'(d_done[k]), 32'(m_phase[k] == 2));
        check("pass", k, 32'(d_pass[k]), 32'(m_pass[k]));
        check("yes_count", k, d_yes[k], 32'(m_yes[k]));
        check("voted_mask", k, d_mask[k], m_mask[k]);
        check("timed_out", k, 32'(d_to[k]), 32'(m_to[k]));
        check("busy_and_done", k, 32'(d_busy[k] & d_done[k]), 32'd0);
        check("done_twice", k, 32'(d_done[k] & prev_done[k]), 32'd0);
        prev_done[k] = d_done[k];
      end
    end
  end

  // Driver tasks: each call presents inputs for exactly one rising edge and
  // returns just after the following falling edge.
  task automatic cyc(input logic [4:0] v, input logic [4:0] y);
    vv = v; vy = y;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(5'b0, 5'b0);
  endtask

  task automatic open_session();
    start = 1'b1;
    cyc(5'b0, 5'b0);
    start = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    logic [2:0] p;
    logic       maj;
    #2;
    check("reset_busy", 0, 32'(busy3), 32'd0);
    check("reset_mask", 0, 32'(mask3), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Reset mid-session with voter 0 already counted.
    open_session();
    cyc(5'b00001, 5'b00001);
    check("pre_reset_mask", 0, 32'(mask3), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 0, 32'(busy3), 32'd0);
    check("async_rst_mask", 0, 32'(mask3), 32'd0);
    check("async_rst_yes", 0, 32'(yc3), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single-cycle unanimous close; N=4 and N=5 time out with 2 yes.
    open_session();
    cyc(5'b00111, 5'b00011);
    check("unan_done", 0, 32'(done3), 32'd1);
    check("unan_yes", 0, 32'(yc3), 32'd2);
    check("unan_pass", 0, 32'(pass3), 32'd1);
    check("unan_to", 0, 32'(to3), 32'd0);
    check("unan_mask", 0, 32'(mask3), 32'h7);
    idle(10);
    check("unan_hold_yes", 0, 32'(yc3), 32'd2);
    check("unan_hold_pass", 0, 32'(pass3), 32'd1);
    check("tie4_yes", 1, 32'(yc4), 32'd2);
    check("tie4_pass", 1, 32'(pass4), 32'd0);
    check("part5_pass", 2, 32'(pass5), 32'd0);
    check("part5_to", 2, 32'(to5), 32'd1);

    // Full turnout, votes 11100.
    open_session();
    cyc(5'b11111, 5'b11100);
    check("n5_pass", 2, 32'(pass5), 32'd1);
    check("n5_yes", 2, 32'(yc5), 32'd3);
    check("n3_pass", 0, 32'(pass3), 32'd0);
    idle(2);

    // Staggered votes with a re-vote from voter 0.
    open_session();
    cyc(5'b00001, 5'b00000);
    cyc(5'b00001, 5'b00001);
    cyc(5'b00010, 5'b00010);
    check("stag_not_done", 0, 32'(done3), 32'd0);
    cyc(5'b00100, 5'b00000);
    check("stag_done", 0, 32'(done3), 32'd1);
    check("stag_yes", 0, 32'(yc3), 32'd1);
    check("stag_pass", 0, 32'(pass3), 32'd0);
    idle(10);

    // Timeout with only voter 2 voting yes in COLLECT cycle 3.
    open_session();
    idle(2);
    cyc(5'b00100, 5'b00100);
    idle(4);
    check("to_not_yet", 0, 32'(done3), 32'd0);
    cyc(5'b0, 5'b0);
    check("to_done", 0, 32'(done3), 32'd1);
    check("to_flag", 0, 32'(to3), 32'd1);
    check("to_mask", 0, 32'(mask3), 32'h4);
    check("to_yes", 0, 32'(yc3), 32'd1);
    check("to_pass", 0, 32'(pass3), 32'd0);
    start = 1'b1;
    cyc(5'b0, 5'b0);
    start = 1'b0;
    check("start_in_done_ignored", 0, 32'(busy3), 32'd0);
    idle(2);
    check("still_idle", 0, 32'(busy3), 32'd0);

    // Exhaustive majority for three voters.
    for (int i = 0; i < 8; i++) begin
      p = 3'(i);
      maj = (p[0] & p[1]) | (p[1] & p[2]) | (p[0] & p[2]);
      open_session();
      cyc(5'b11111, {2'b00, p});
      check("majority", 0, 32'(pass3), 32'(maj));
      idle(1);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
